// File: rtl/motoro301_pkg.sv
// Shared types and defaults for the motoro301 three-phase dead-time guard.
// Phase states, default timing and the state-to-gate mapping live here.
package motoro301_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DEAD = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } phaseState_t;

    localparam int DEAD_CYC_DEF   = 50;
    localparam int FAULT_HOLD_DEF = 5000;

    // Gate levels {xHP, xLN}; the high-side drive is active-low.
    function automatic logic [1:0] gateOf(input phaseState_t s);
        case (s)
            HI:      gateOf = 2'b00;
            LO:      gateOf = 2'b11;
            default: gateOf = 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/motoro301_dt_phase.sv
// One half-bridge phase: request register, OFF/DEAD/HI/LO state machine and
// dead-time counter. Gate outputs are registered from the next state.
module motoro301_dt_phase
    import motoro301_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF
) (
    input  logic clk50mhz,
    input  logic nReset,
    input  logic i_hiReq,
    input  logic i_loReq,
    input  logic i_kill,
    output logic o_hp,
    output logic o_ln,
    output logic o_dead
);

    localparam logic [7:0] CNT_LOAD = 8'(DEAD_CYC - 1);

    logic        r_hiReq;
    logic        r_loReq;
    phaseState_t r_state;
    logic [7:0]  r_cnt;
    logic        r_hp;
    logic        r_ln;
    logic        r_dead;

    phaseState_t w_target;
    phaseState_t w_next;
    logic        w_loadCnt;
    logic [1:0]  w_gate;

    always_comb begin
        w_target = OFF;
        if (r_hiReq && !r_loReq) begin
            w_target = HI;
        end else if (r_loReq && !r_hiReq) begin
            w_target = LO;
        end
    end

    // Any move onto a switch goes through DEAD; dropping to OFF is immediate.
    always_comb begin
        w_next    = r_state;
        w_loadCnt = 1'b0;
        if (i_kill) begin
            w_next = OFF;
        end else begin
            case (r_state)
                OFF: begin
                    if (w_target != OFF) begin
                        w_next    = DEAD;
                        w_loadCnt = 1'b1;
                    end
                end
                DEAD: begin
                    if (r_cnt == 8'd0) begin
                        w_next = w_target;
                    end
                end
                HI: begin
                    if (w_target == LO) begin
                        w_next    = DEAD;
                        w_loadCnt = 1'b1;
                    end else if (w_target == OFF) begin
                        w_next = OFF;
                    end
                end
                LO: begin
                    if (w_target == HI) begin
                        w_next    = DEAD;
                        w_loadCnt = 1'b1;
                    end else if (w_target == OFF) begin
                        w_next = OFF;
                    end
                end
                default: w_next = OFF;
            endcase
        end
    end

    assign w_gate = gateOf(w_next);

    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            r_hiReq <= 1'b0;
            r_loReq <= 1'b0;
            r_state <= OFF;
            r_cnt   <= 8'd0;
            r_hp    <= 1'b1;
            r_ln    <= 1'b0;
            r_dead  <= 1'b0;
        end else begin
            r_hiReq <= i_hiReq;
            r_loReq <= i_loReq;
            r_state <= w_next;
            r_hp    <= w_gate[1];
            r_ln    <= w_gate[0];
            r_dead  <= (w_next == DEAD);
            if (i_kill) begin
                r_cnt <= 8'd0;
            end else if (w_loadCnt) begin
                r_cnt <= CNT_LOAD;
            end else if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign o_hp   = r_hp;
    assign o_ln   = r_ln;
    assign o_dead = r_dead;

endmodule

// File: rtl/motoro301_deadtime_guard.sv
// Three-phase gate-drive guard: per-phase dead-time FSMs plus a shoot-through
// fault latch with a minimum hold time before it may be cleared.
module motoro301_deadtime_guard
    import motoro301_pkg::*;
#(
    parameter int DEAD_CYC   = DEAD_CYC_DEF,
    parameter int FAULT_HOLD = FAULT_HOLD_DEF
) (
    input  logic       clk50mhz,
    input  logic       nReset,
    input  logic [2:0] hiReq,
    input  logic [2:0] loReq,
    input  logic       m3forceStop,
    input  logic       faultClr,
    output logic       aHP,
    output logic       bHP,
    output logic       cHP,
    output logic       aLN,
    output logic       bLN,
    output logic       cLN,
    output logic       fault,
    output logic       tp01
);

    localparam int                HOLD_W    = $clog2(FAULT_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FAULT_HOLD);

    logic              r_fault;
    logic [HOLD_W-1:0] r_hold;
    logic              r_tp01;

    logic       w_setFault;
    logic       w_kill;
    logic [2:0] w_hp;
    logic [2:0] w_ln;
    logic [2:0] w_dead;

    // The raw set term joins the kill so no switch turns on in the set cycle.
    assign w_setFault = |(hiReq & loReq);
    assign w_kill     = m3forceStop | r_fault | w_setFault;

    for (genvar g = 0; g < 3; g++) begin : g_phase
        motoro301_dt_phase #(
            .DEAD_CYC (DEAD_CYC)
        ) u_phase (
            .clk50mhz (clk50mhz),
            .nReset   (nReset),
            .i_hiReq  (hiReq[g]),
            .i_loReq  (loReq[g]),
            .i_kill   (w_kill),
            .o_hp     (w_hp[g]),
            .o_ln     (w_ln[g]),
            .o_dead   (w_dead[g])
        );
    end

    // A new set always wins over a clear and restarts the hold window.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            r_fault <= 1'b0;
            r_hold  <= '0;
            r_tp01  <= 1'b0;
        end else begin
            r_tp01 <= |w_dead;
            if (w_setFault) begin
                r_fault <= 1'b1;
                r_hold  <= HOLD_LOAD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end else if (faultClr) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign {cHP, bHP, aHP} = w_hp;
    assign {cLN, bLN, aLN} = w_ln;
    assign fault           = r_fault;
    assign tp01            = r_tp01;

endmodule

// File: tb/tb_motoro301_deadtime_guard.sv
// Self-checking bench for motoro301_deadtime_guard: directed scenarios with a
// queued expectation per clock, then a randomized shoot-through/gap monitor.
module tb_motoro301_deadtime_guard;

    localparam int DC = 50;

    typedef struct packed {
        logic [2:0] hp;
        logic [2:0] ln;
        logic       flt;
    } exp_t;

    logic       clk50mhz    = 1'b0;
    logic       nReset      = 1'b0;
    logic [2:0] hiReq       = 3'b000;
    logic [2:0] loReq       = 3'b000;
    logic       m3forceStop = 1'b0;
    logic       faultClr    = 1'b0;
    logic       aHP, bHP, cHP, aLN, bLN, cLN, fault, tp01;
    logic [2:0] hpV;
    logic [2:0] lnV;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    assign hpV = {cHP, bHP, aHP};
    assign lnV = {cLN, bLN, aLN};

    always #10 clk50mhz = ~clk50mhz;

    motoro301_deadtime_guard dut (
        .clk50mhz    (clk50mhz),
        .nReset      (nReset),
        .hiReq       (hiReq),
        .loReq       (loReq),
        .m3forceStop (m3forceStop),
        .faultClr    (faultClr),
        .aHP         (aHP),
        .bHP         (bHP),
        .cHP         (cHP),
        .aLN         (aLN),
        .bLN         (bLN),
        .cLN         (cLN),
        .fault       (fault),
        .tp01        (tp01)
    );

    task automatic test_reset();
        exp_t e;
        nReset = 1'b0;
        hiReq  = 3'b111;
        for (int p = 1; p <= 3; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: 3'b111, ln: 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault, tp01} !== {e.hp, e.ln, e.flt, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset p=%0d hp=%b ln=%b fault=%b tp01=%b, expected hp=%b ln=%b fault=%b tp01=0",
                         p, hpV, lnV, fault, tp01, e.hp, e.ln, e.flt);
            end
        end
        hiReq  = 3'b000;
        nReset = 1'b1;
    endtask

    task automatic test_hi_on();
        exp_t e;
        hiReq = 3'b001;
        for (int p = 1; p <= 60; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: (p >= DC + 2) ? 3'b110 : 3'b111, ln: 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL hi_on p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
            if (p == 10 || p == 60) begin
                checks++;
                if (tp01 !== (p == 10)) begin
                    errors++;
                    $display("[TB] FAIL hi_on_tp01 p=%0d tp01=%b, expected %b", p, tp01, p == 10);
                end
            end
        end
    endtask

    task automatic test_hi_to_lo();
        exp_t e;
        hiReq = 3'b000;
        loReq = 3'b001;
        for (int p = 1; p <= 60; p++) begin
            @(posedge clk50mhz);
            if (p == 1)
                expQ.push_back('{hp: 3'b110, ln: 3'b000, flt: 1'b0});
            else
                expQ.push_back('{hp: 3'b111, ln: (p >= DC + 2) ? 3'b001 : 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL hi_to_lo p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
        end
    endtask

    task automatic test_dead_abort();
        exp_t e;
        loReq = 3'b000;
        for (int p = 1; p <= 5; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: 3'b111, ln: (p == 1) ? 3'b001 : 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, tp01} !== {e.hp, e.ln, 1'b0}) begin
                errors++;
                $display("[TB] FAIL lo_off p=%0d hp=%b ln=%b tp01=%b, expected hp=%b ln=%b tp01=0",
                         p, hpV, lnV, tp01, e.hp, e.ln);
            end
        end
        hiReq = 3'b001;
        for (int p = 1; p <= 70; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: 3'b111, ln: 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL dead_abort p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
            if (p == DC + 1 || p == DC + 4) begin
                checks++;
                if (tp01 !== (p == DC + 1)) begin
                    errors++;
                    $display("[TB] FAIL dead_abort_tp01 p=%0d tp01=%b, expected %b", p, tp01, p == DC + 1);
                end
            end
            if (p == 21) hiReq = 3'b000;
        end
    endtask

    task automatic test_dead_retarget();
        exp_t e;
        hiReq = 3'b001;
        for (int p = 1; p <= 60; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: 3'b111, ln: (p >= DC + 2) ? 3'b001 : 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL dead_retarget p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
            if (p == 11) begin
                hiReq = 3'b000;
                loReq = 3'b001;
            end
        end
    endtask

    task automatic test_fault();
        exp_t e;
        hiReq = 3'b001;
        loReq = 3'b000;
        for (int p = 1; p <= 60; p++) begin
            @(posedge clk50mhz);
            if (p == 1)
                expQ.push_back('{hp: 3'b111, ln: 3'b001, flt: 1'b0});
            else
                expQ.push_back('{hp: (p >= DC + 2) ? 3'b110 : 3'b111, ln: 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL lo_to_hi p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
        end
        hiReq = 3'b011;
        loReq = 3'b010;
        for (int p = 1; p <= 5060; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: (p >= 5003 + DC) ? 3'b110 : 3'b111, ln: 3'b000, flt: (p < 5002)});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL fault_hold p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
            if (p == 1) begin
                hiReq = 3'b001;
                loReq = 3'b000;
            end
            faultClr = (p == 99 || p == 5000 || p == 5001);
        end
    endtask

    task automatic test_set_wins();
        exp_t e;
        hiReq = 3'b101;
        loReq = 3'b100;
        for (int p = 1; p <= 5010; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: 3'b111, ln: 3'b000, flt: 1'b1});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL set_wins p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
            if (p == 5001) begin
                hiReq = 3'b101;
                loReq = 3'b100;
            end else begin
                hiReq = 3'b001;
                loReq = 3'b000;
            end
            faultClr = (p == 5001 || p == 5002);
        end
    endtask

    task automatic test_force_stop();
        exp_t e;
        nReset = 1'b0;
        @(posedge clk50mhz);
        @(negedge clk50mhz);
        nReset = 1'b1;
        hiReq  = 3'b111;
        loReq  = 3'b000;
        for (int p = 1; p <= 60; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: (p >= DC + 2) ? 3'b000 : 3'b111, ln: 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL all_hi p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
        end
        m3forceStop = 1'b1;
        for (int p = 1; p <= 60; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: (p >= DC + 2) ? 3'b000 : 3'b111, ln: 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL force_stop p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
            m3forceStop = 1'b0;
        end
    endtask

    task automatic test_reset_async();
        exp_t e;
        #3 nReset = 1'b0;
        #1;
        checks++;
        if ({hpV, lnV, tp01} !== {3'b111, 3'b000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset_hi hp=%b ln=%b tp01=%b, expected hp=111 ln=000 tp01=0", hpV, lnV, tp01);
        end
        @(negedge clk50mhz);
        hiReq  = 3'b000;
        loReq  = 3'b001;
        nReset = 1'b1;
        for (int p = 1; p <= 60; p++) begin
            @(posedge clk50mhz);
            expQ.push_back('{hp: 3'b111, ln: (p >= DC + 2) ? 3'b001 : 3'b000, flt: 1'b0});
            @(negedge clk50mhz);
            e = expQ.pop_front();
            checks++;
            if ({hpV, lnV, fault} !== {e.hp, e.ln, e.flt}) begin
                errors++;
                $display("[TB] FAIL reset_release p=%0d hp=%b ln=%b fault=%b, expected hp=%b ln=%b fault=%b",
                         p, hpV, lnV, fault, e.hp, e.ln, e.flt);
            end
        end
        #3 nReset = 1'b0;
        #1;
        checks++;
        if ({hpV, lnV} !== {3'b111, 3'b000}) begin
            errors++;
            $display("[TB] FAIL async_reset_lo hp=%b ln=%b, expected hp=111 ln=000", hpV, lnV);
        end
        @(negedge clk50mhz);
        loReq  = 3'b000;
        nReset = 1'b1;
    endtask

    // Random traffic: no phase may show both switches on, and a switch may only
    // turn on after at least DC sampled cycles with both switches of that phase off.
    task automatic test_random();
        int mode[3];
        int lastOn[3];
        int offRun[3];
        int cur;
        int k;
        for (int j = 0; j < 3; j++) begin
            mode[j]   = 0;
            lastOn[j] = 0;
            offRun[j] = DC;
        end
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk50mhz);
            @(negedge clk50mhz);
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (hpV[j] === 1'b0 && lnV[j] === 1'b1) begin
                    errors++;
                    $display("[TB] FAIL shoot_through cyc=%0d phase=%0d hp=%b ln=%b, required not both on",
                             i, j, hpV[j], lnV[j]);
                end
                cur = (hpV[j] === 1'b0) ? 1 : ((lnV[j] === 1'b1) ? 2 : 0);
                if (cur == 0) begin
                    offRun[j]++;
                end else begin
                    if (lastOn[j] != 0 && cur != lastOn[j]) begin
                        checks++;
                        if (offRun[j] < DC) begin
                            errors++;
                            $display("[TB] FAIL dead_gap cyc=%0d phase=%0d gap=%0d, required at least %0d",
                                     i, j, offRun[j], DC);
                        end
                    end
                    lastOn[j] = cur;
                    offRun[j] = 0;
                end
            end
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(0, 29) == 0) mode[j] = int'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 5999) == 0) begin
                k       = int'($urandom_range(0, 2));
                mode[k] = 3;
            end
            for (int j = 0; j < 3; j++) begin
                hiReq[j] = (mode[j] == 1 || mode[j] == 3);
                loReq[j] = (mode[j] == 2 || mode[j] == 3);
            end
            m3forceStop = ($urandom_range(0, 199) == 0);
            faultClr    = ($urandom_range(0, 19) == 0);
            nReset      = ($urandom_range(0, 2999) != 0);
        end
        nReset      = 1'b1;
        hiReq       = 3'b000;
        loReq       = 3'b000;
        m3forceStop = 1'b0;
        faultClr    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hi_on();
        test_hi_to_lo();
        test_dead_abort();
        test_dead_retarget();
        test_fault();
        test_set_wins();
        test_force_stop();
        test_reset_async();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
